row_packer: RTL and testbench
=============================

# row_packer

Upstream feeder for the normal-to-ready (n2r) stage. Accepts a narrow valid/ready stream of fixed-point elements in row-major order and packs each matrix row into one WIDTH*COL-bit word. Rows are handed downstream over a valid/ready handshake through two ping-pong row banks, so input streaming continues while the previous row waits. Packed rows match the n2r input format: element 0 of a row sits at the MSB end.

## Interface
- WIDTH, 16: bits per fixed-point element.
- COL, 256: elements per row; COL % IN_ELEMS == 0 is mandatory (elaboration error otherwise).
- ROW, 2754: rows per matrix.
- IN_ELEMS, 4: elements per input beat; BEATS = COL/IN_ELEMS beats per row.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  WIDTH*IN_ELEMS  beat; element 0 in the MSB slice.
- s_last  in  1  marks the final beat of the matrix.
- row_valid  out  1  packed row available.
- row_ready  in  1  downstream (n2r) takes the row when row_valid && row_ready.
- row_data  out  WIDTH*COL  packed row; element e at [WIDTH*COL-1-e*WIDTH -: WIDTH].
- row_last  out  1  qualifies row_data as row ROW-1.
- frame_done  out  1  one-cycle pulse when the row_last row is taken.
- err  out  1  sticky flag for an s_last/row-boundary mismatch.

## Operation
- State: bank[0:1] (WIDTH*COL each), full[1:0], last_tag[1:0], wr_sel, rd_sel, beat_cnt (0..BEATS-1), row_cnt (0..ROW-1).
- s_ready = !full[wr_sel].
- Accepted beat: write s_data into bank[wr_sel] slice [WIDTH*COL-1 - beat_cnt*WIDTH*IN_ELEMS -: WIDTH*IN_ELEMS], then increment beat_cnt.
- At beat_cnt == BEATS-1 the write completes the row:
  - set full[wr_sel];
  - last_tag[wr_sel] = (row_cnt == ROW-1);
  - toggle wr_sel;
  - beat_cnt <= 0;
  - row_cnt increments and wraps to 0 after ROW-1.
- row_valid = full[rd_sel]; row_data = bank[rd_sel]; row_last = full[rd_sel] && last_tag[rd_sel].
- On row handshake: clear full[rd_sel], toggle rd_sel. frame_done is registered and pulses the next cycle if row_last was set.
- Per-bank states: EMPTY -> FILLING (wr_sel points here) -> FULL -> EMPTY on handshake.
- Simultaneous row completion and row handshake always act on different banks; both take effect in the same cycle.
- err sets when s_last is accepted on any beat other than beat BEATS-1 of row ROW-1, or when that beat arrives with s_last low. The beat is still stored. err clears only on reset.
- Reset mid-operation: partial rows and full banks are discarded. Bank contents are not reset.

## Timing
- Reset values: s_ready=1, row_valid=0, row_last=0, frame_done=0, err=0, all pointers and counters 0.
- Latency: if the last beat of a row is accepted at edge t, row_valid is high after edge t (same cycle as the next beat).
- Throughput: 1 beat/cycle sustained if each row is taken within BEATS cycles of presentation. Otherwise s_ready drops once both banks are full, and rises the cycle after a row handshake.
- row_data and row_last are stable while row_valid && !row_ready. s_data may change freely when not accepted.

## Structure
- Shared package matmul_pkg holds:
  - the element WIDTH/FRAC_WIDTH constants;
  - BEATS;
  - counter widths via $clog2 (beat_cnt, row_cnt).
- The n2r stage imports the same package.
- One sub-module, row_bank: a WIDTH*COL register with beat-indexed write enable, instantiated twice.
- Handshake/pointer logic lives in row_packer.

## Test plan
Bench parameters: WIDTH=16, COL=8, IN_ELEMS=4, ROW=4 (BEATS=2).
- Directed fill: beats 0x0001_0002_0003_0004 then 0x0005_0006_0007_0008 with row_ready=1 -> row_valid for 1 cycle with row_data=0x0001..0008 (element 0 at MSB), row_last=0.
- Back-pressure: row_ready=0, stream 3 rows continuously -> s_ready falls after beat 4 (both banks full). Raise row_ready for 1 cycle -> row 0 delivered, s_ready=1 next cycle, row 2 completes, no data lost.
- Frame end: 8 beats, s_last on beat 8 -> row_last with row 3 only, frame_done pulses once the cycle after its handshake, err=0, row_cnt back to 0.
- Protocol error: s_last on beat 3 -> err=1 and stays 1 through later rows until rst_n=0.
- Reset mid-row: 1 beat accepted, then rst_n low 1 cycle -> row_valid=0, s_ready=1. The next 2 beats form a fresh row 0.
- Random s_valid/row_ready at 50% for 1000 rows -> scoreboard matches all rows in order, frame_done count = 250.

Source files
------------

// File: rtl/matmul_pkg.sv
// matmul_pkg: element format, default matrix geometry and counter sizing shared by row_packer and n2r
package matmul_pkg;
  localparam int ELEM_WIDTH   = 16;
  localparam int FRAC_WIDTH   = 8;
  localparam int DEF_COL      = 256;
  localparam int DEF_ROW      = 2754;
  localparam int DEF_IN_ELEMS = 4;
  localparam int DEF_BEATS    = DEF_COL / DEF_IN_ELEMS;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int BEAT_CNT_W = cnt_w(DEF_BEATS);
  localparam int ROW_CNT_W  = cnt_w(DEF_ROW);
endpackage

// File: rtl/row_bank.sv
// row_bank: one packed-row register written a beat at a time, beat 0 at the MSB end
module row_bank import matmul_pkg::*; #(
  parameter int WIDTH    = ELEM_WIDTH,
  parameter int COL      = DEF_COL,
  parameter int IN_ELEMS = DEF_IN_ELEMS,
  parameter int BW       = cnt_w(COL / IN_ELEMS)
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [BW-1:0]             beat_i,
  input  logic [WIDTH*IN_ELEMS-1:0] data_i,
  output logic [WIDTH*COL-1:0]      bank_o
);
  localparam int SW = WIDTH * IN_ELEMS;
  logic [WIDTH*COL-1:0] bank_q;
  always_ff @(posedge clk)
    if (we_i) bank_q[WIDTH*COL-1 - int'(beat_i)*SW -: SW] <= data_i;
  assign bank_o = bank_q;
endmodule

// File: rtl/row_packer.sv
// row_packer: packs a beat stream into whole rows and hands them to n2r through two ping-pong banks
module row_packer import matmul_pkg::*; #(
  parameter int WIDTH    = ELEM_WIDTH,
  parameter int COL      = DEF_COL,
  parameter int ROW      = DEF_ROW,
  parameter int IN_ELEMS = DEF_IN_ELEMS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH*IN_ELEMS-1:0] s_data,
  input  logic                      s_last,
  output logic                      row_valid,
  input  logic                      row_ready,
  output logic [WIDTH*COL-1:0]      row_data,
  output logic                      row_last,
  output logic                      frame_done,
  output logic                      err
);
  localparam int BEATS = COL / IN_ELEMS;
  localparam int BW    = cnt_w(BEATS);
  localparam int RW    = cnt_w(ROW);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(ROW - 1);
  if (COL % IN_ELEMS != 0) begin : g_cfg_err
    $error("row_packer: COL must be a multiple of IN_ELEMS");
  end
  logic [1:0]           full_q, full_d, tag_q, tag_d;
  logic                 wr_sel_q, rd_sel_q, frame_done_q, err_q;
  logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
  logic [RW-1:0]        row_cnt_q, row_cnt_d;
  logic                 acc, row_end, frame_end, take;
  logic [WIDTH*COL-1:0] bank_q [2];
  for (genvar b = 0; b < 2; b++) begin : g_bank
    row_bank #(.WIDTH(WIDTH), .COL(COL), .IN_ELEMS(IN_ELEMS), .BW(BW)) u_bank (
      .clk    (clk),
      .we_i   (acc && wr_sel_q == 1'(b)),
      .beat_i (beat_cnt_q),
      .data_i (s_data),
      .bank_o (bank_q[b])
    );
  end
  assign s_ready    = !full_q[wr_sel_q];
  assign acc        = s_valid && s_ready;
  assign row_end    = acc && beat_cnt_q == LAST_BEAT;
  assign frame_end  = row_cnt_q == LAST_ROW;
  assign row_valid  = full_q[rd_sel_q];
  assign row_data   = bank_q[rd_sel_q];
  assign row_last   = row_valid && tag_q[rd_sel_q];
  assign take       = row_valid && row_ready;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  // Completion and handshake never target the same bank, so both updates apply together.
  always_comb begin
    full_d = full_q;
    tag_d  = tag_q;
    if (take) full_d[rd_sel_q] = 1'b0;
    if (row_end) begin
      full_d[wr_sel_q] = 1'b1;
      tag_d[wr_sel_q]  = frame_end;
    end
    beat_cnt_d = !acc ? beat_cnt_q : row_end ? '0 : beat_cnt_q + 1'b1;
    row_cnt_d  = !row_end ? row_cnt_q : frame_end ? '0 : row_cnt_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q       <= '0;
      tag_q        <= '0;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      beat_cnt_q   <= '0;
      row_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      full_q       <= full_d;
      tag_q        <= tag_d;
      wr_sel_q     <= wr_sel_q ^ row_end;
      rd_sel_q     <= rd_sel_q ^ take;
      beat_cnt_q   <= beat_cnt_d;
      row_cnt_q    <= row_cnt_d;
      frame_done_q <= take && row_last;
      err_q        <= err_q | (acc && (s_last != (row_end && frame_end)));
    end
  end
endmodule

// File: tb/tb_row_packer.sv
// tb_row_packer: directed and random stimulus checked every cycle against a queue-of-rows model
module tb_row_packer;
  localparam int W = 16, C = 8, I = 4, R = 4, B = C / I, DW = W * C, SW = W * I;
  logic clk = 0, rst_n = 0, s_valid = 0, s_last = 0, s_ready;
  logic row_valid, row_ready, row_last, frame_done, err;
  logic rr_man = 0, rr_rand = 0, rand_rdy = 0, chk_en = 0;
  logic [SW-1:0] s_data = '0;
  logic [DW-1:0] row_data;
  assign row_ready = rand_rdy ? rr_rand : rr_man;
  row_packer #(.WIDTH(W), .COL(C), .ROW(R), .IN_ELEMS(I)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
    .row_last(row_last), .frame_done(frame_done), .err(err)
  );
  always #5 clk = ~clk;
  typedef struct {logic [DW-1:0] d; bit last;} row_t;
  row_t q[$];
  logic [DW-1:0] cur = '0;
  int m_beat = 0, m_row = 0, taken = 0, fd_cnt = 0, checks = 0, failures = 0;
  bit m_err = 0, m_fd = 0;
  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin failures++; $display("FAIL %s: got %b expected %b", name, act, exp); end
  endtask
  task automatic checkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin failures++; $display("FAIL %s: got %h expected %h", name, act, exp); end
  endtask
  task automatic checki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin failures++; $display("FAIL %s: got %0d expected %0d", name, act, exp); end
  endtask
  // Model: a FIFO of at most two finished rows; element e of a row is beat e/I, lane e%I.
  task automatic model_step();
    bit rdy, want_last;
    if (!rst_n) begin
      q.delete(); m_beat = 0; m_row = 0; m_err = 0; m_fd = 0;
    end else begin
      rdy = q.size() < 2;
      m_fd = 0;
      if (q.size() > 0 && row_ready) begin m_fd = q[0].last; void'(q.pop_front()); taken++; end
      if (s_valid && rdy) begin
        for (int e = 0; e < I; e++) cur[DW-1-(m_beat*I+e)*W -: W] = s_data[SW-1-e*W -: W];
        want_last = m_beat == B - 1 && m_row == R - 1;
        if (s_last != want_last) m_err = 1;
        if (m_beat == B - 1) begin
          q.push_back('{d: cur, last: (m_row == R - 1)});
          m_row = (m_row + 1) % R;
          m_beat = 0;
        end else m_beat++;
      end
    end
  endtask
  initial forever begin @(posedge clk); model_step(); end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check1("s_ready", s_ready, q.size() < 2);
      check1("row_valid", row_valid, q.size() > 0);
      check1("row_last", row_last, q.size() > 0 && q[0].last);
      if (q.size() > 0) checkd("row_data", row_data, q[0].d);
      check1("frame_done", frame_done, m_fd);
      check1("err", err, m_err);
    end
    if (frame_done === 1'b1) fd_cnt++;
    rr_rand = 1'($urandom % 2);
  end
  task automatic send(input logic [SW-1:0] d, input bit l, input bit gap);
    int n = 0;
    if (gap) while ($urandom % 2 == 1) @(negedge clk);
    s_valid = 1; s_data = d; s_last = l;
    while (!s_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin checks++; failures++; $display("FAIL send_timeout: s_ready low for %0d cycles, required 1", n); end
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask
  initial begin
    int fd0, t0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    check1("rst_s_ready", s_ready, 1);
    check1("rst_row_valid", row_valid, 0);
    check1("rst_row_last", row_last, 0);
    check1("rst_frame_done", frame_done, 0);
    check1("rst_err", err, 0);
    rst_n = 1;
    rr_man = 1;
    send(64'h0001_0002_0003_0004, 0, 0);
    send(64'h0005_0006_0007_0008, 0, 0);
    check1("fill_valid", row_valid, 1);
    checkd("fill_data", row_data, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
    check1("fill_last", row_last, 0);
    @(negedge clk);
    check1("fill_valid_one_cycle", row_valid, 0);
    rr_man = 0;
    for (int k = 0; k < 4; k++) send({$urandom, $urandom}, 0, 0);
    check1("bp_ready_low", s_ready, 0);
    rr_man = 1;
    @(negedge clk);
    rr_man = 0;
    check1("bp_ready_back", s_ready, 1);
    fd0 = fd_cnt;
    send({$urandom, $urandom}, 0, 0);
    send({$urandom, $urandom}, 1, 0);
    check1("bp_front_not_last", row_last, 0);
    rr_man = 1;
    repeat (4) @(negedge clk);
    checki("frame_done_once", fd_cnt - fd0, 1);
    check1("frame_err_clear", err, 0);
    for (int k = 0; k < 8; k++) begin
      send({$urandom, $urandom}, k == 2, 0);
      if (k == 2) check1("perr_set", err, 1);
    end
    for (int k = 0; k < 8; k++) send({$urandom, $urandom}, k == 7, 0);
    check1("perr_sticky", err, 1);
    send(64'hdead_beef_0bad_f00d, 0, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check1("mid_rst_valid", row_valid, 0);
    check1("mid_rst_ready", s_ready, 1);
    check1("mid_rst_err", err, 0);
    send(64'h1111_2222_3333_4444, 0, 0);
    send(64'h5555_6666_7777_8888, 0, 0);
    checkd("mid_rst_row0", row_data, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    fd0 = fd_cnt;
    t0 = taken;
    rand_rdy = 1;
    for (int k = 0; k < 2000; k++) send({$urandom, $urandom}, k % 8 == 7, 1);
    rand_rdy = 0;
    rr_man = 1;
    repeat (6) @(negedge clk);
    checki("rand_rows", taken - t0, 1000);
    checki("rand_frames", fd_cnt - fd0, 250);
    check1("rand_err", err, 0);
    check1("rand_drained", row_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
